// File: rtl/pwm_pkg.sv
//------------------------------------------------------------------------------
// Module  : pwm_pkg
// Brief   : Shared defaults and config-FSM state encoding for pwm_scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pwm_pkg;

  // Default build of the scheduler: 4 channels, 50 MHz / 16 = 3.125 MHz tick.
  localparam int c_N_CH  = 4;
  localparam int c_DIV   = 16;
  localparam int c_CNT_W = 8;

  // Config write sequencing: one staged write waits for a period boundary.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_tick_gen.sv
//------------------------------------------------------------------------------
// Module  : pwm_tick_gen
// Brief   : Prescaler producing a registered one-cycle tick every DIV cycles,
//           with run enable and synchronous clear.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int DIV = c_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int              PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   c_LAST = PW'(DIV - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick;

  // Count 0..DIV-1; tick is registered so it appears DIV edges after start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (i_clr) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (i_en) begin
      r_presc <= (r_presc == c_LAST) ? '0 : r_presc + 1'b1;
      r_tick  <= (r_presc == c_LAST);
    end else begin
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule : pwm_tick_gen

`default_nettype wire

// File: rtl/pwm_scheduler.sv
//------------------------------------------------------------------------------
// Module  : pwm_scheduler
// Brief   : N-channel PWM sharing one prescaled period counter; duty/period
//           writes are staged and committed only at period boundaries (or
//           immediately while stopped).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_scheduler
  import pwm_pkg::*;
#(
  parameter int N_CH  = c_N_CH,
  parameter int DIV   = c_DIV,
  parameter int CNT_W = c_CNT_W
) (
  input  logic                    i_clk_50M,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic                    i_cfg_is_period,
  input  logic [$clog2(N_CH)-1:0] i_cfg_ch,
  input  logic [CNT_W-1:0]        i_cfg_data,
  output logic                    o_tick,
  output logic                    o_period_start,
  output logic [N_CH-1:0]         o_pwm_out
);

  localparam int W_CH = $clog2(N_CH);

  cfg_state_e        r_state;
  cfg_state_e        w_state_nxt;
  logic              w_cfg_ready;
  logic              w_capture;
  logic              w_commit;

  logic              w_tick;
  logic              w_adv;
  logic              w_wrap;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_d;
  logic              r_period_start;

  logic [CNT_W-1:0]  r_period_act;
  logic [CNT_W-1:0]  r_duty_act [N_CH];

  logic              r_stg_is_period;
  logic [W_CH-1:0]   r_stg_ch;
  logic [CNT_W-1:0]  r_stg_data;

  logic [N_CH-1:0]   w_pwm_d;
  logic [N_CH-1:0]   r_pwm;

  pwm_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .i_clk   (i_clk_50M),
    .i_rst_n (i_rst_n),
    .i_en    (i_enable),
    .i_clr   (!i_enable),
    .o_tick  (w_tick)
  );

  assign w_adv  = w_tick && i_enable;
  // '>=' keeps the counter bounded even if the period ever shrank below cnt.
  assign w_wrap = (r_cnt >= r_period_act);

  // Next counter value: cleared while stopped, advanced or wrapped on tick.
  always_comb begin
    w_cnt_d = r_cnt;
    if (!i_enable) begin
      w_cnt_d = '0;
    end else if (w_adv) begin
      w_cnt_d = w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  // Period counter and boundary strobe, registered alongside the new count.
  always_ff @(posedge i_clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_d;
      r_period_start <= w_adv && w_wrap;
    end
  end

  // Config FSM state register.
  always_ff @(posedge i_clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Config FSM next state: a pending write commits on a boundary or when stopped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_cfg_valid) w_state_nxt = ST_PEND;
      ST_PEND:   if (r_period_start || !i_enable) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Config FSM outputs: ready is a pure function of state.
  always_comb begin
    w_cfg_ready = (r_state == ST_IDLE);
    w_commit    = (r_state == ST_COMMIT);
    w_capture   = w_cfg_ready && i_cfg_valid;
  end

  // Single staging entry, loaded on handshake and dropped by reset.
  always_ff @(posedge i_clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stg_is_period <= 1'b0;
      r_stg_ch        <= '0;
      r_stg_data      <= '0;
    end else if (w_capture) begin
      r_stg_is_period <= i_cfg_is_period;
      r_stg_ch        <= i_cfg_ch;
      r_stg_data      <= i_cfg_data;
    end
  end

  // Active period/duty registers, written only in the COMMIT state.
  always_ff @(posedge i_clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period_act <= '1;
      for (int i = 0; i < N_CH; i++) begin
        r_duty_act[i] <= '0;
      end
    end else if (w_commit) begin
      if (r_stg_is_period) begin
        r_period_act <= r_stg_data;
      end else begin
        r_duty_act[r_stg_ch] <= r_stg_data;
      end
    end
  end

  // Per-channel compare against next count and next duty, so outputs line up
  // with the counter and a committed duty shows up one cycle after COMMIT.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] w_duty_d;
    assign w_duty_d    = (w_commit && !r_stg_is_period && (r_stg_ch == W_CH'(gi)))
                         ? r_stg_data : r_duty_act[gi];
    assign w_pwm_d[gi] = i_enable && (w_cnt_d < w_duty_d);
  end

  // Registered PWM pins.
  always_ff @(posedge i_clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_pwm_d;
    end
  end

  assign o_cfg_ready    = w_cfg_ready;
  assign o_tick         = w_tick;
  assign o_period_start = r_period_start;
  assign o_pwm_out      = r_pwm;

endmodule : pwm_scheduler

`default_nettype wire
